// File: rtl/mux_sel_arbiter_if.sv
// rtl/mux_sel_arbiter_if.sv - request/data inputs and grant/select/data outputs of the mux arbiter
interface mux_sel_arbiter_if;
  logic [3:0] req;
  logic [3:0] d;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;
  logic       y;
  logic       ny;

  // Requesting side: drives requests and mux data, observes grants and data out
  modport master (
    output req,
    output d,
    input  sel,
    input  gnt,
    input  busy,
    input  y,
    input  ny
  );

  // Arbiter side
  modport slave (
    input  req,
    input  d,
    output sel,
    output gnt,
    output busy,
    output y,
    output ny
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin owner of a 4:1 one-bit mux with bounded hold time
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           state;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [1:0]       scan_idx;
  logic             owner_req;
  logic             others_pending;

  // Round-robin search from rr_ptr upward; while granted rr_ptr sits just past
  // the owner, so any other requester is found before the owner itself.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    scan_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_ptr + 2'(i);
      if (!pick_valid && bus.req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Owner status: sel always names the owner while in GRANT
  always_comb begin
    owner_req      = bus.req[bus.sel];
    others_pending = |(bus.req & ~bus.gnt);
  end

  // Grant FSM, hold counter, and registered data path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      hold_cnt <= '0;
      bus.gnt  <= 4'b0000;
      bus.sel  <= 2'd0;
      bus.busy <= 1'b0;
      bus.y    <= 1'b0;
      bus.ny   <= 1'b1;
    end else begin
      // Data lags the select by one cycle and uses the pre-edge busy/sel
      bus.y  <= bus.busy ? bus.d[bus.sel]  : 1'b0;
      bus.ny <= bus.busy ? ~bus.d[bus.sel] : 1'b1;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= GRANT;
            bus.gnt  <= 4'b0001 << pick_idx;
            bus.sel  <= pick_idx;
            bus.busy <= 1'b1;
            hold_cnt <= CNT_W'(1);
            rr_ptr   <= pick_idx + 2'd1;
          end
        end
        GRANT: begin
          if (!owner_req && !others_pending) begin
            state    <= IDLE;
            bus.gnt  <= 4'b0000;
            bus.busy <= 1'b0;
            hold_cnt <= '0;
          end else if (!owner_req || (hold_cnt == HOLD_MAX && others_pending)) begin
            // Handoff or preemption, both without an idle bubble
            bus.gnt  <= 4'b0001 << pick_idx;
            bus.sel  <= pick_idx;
            hold_cnt <= CNT_W'(1);
            rr_ptr   <= pick_idx + 2'd1;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - directed self-checking bench for mux_sel_arbiter
module tb_mux_sel_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux_sel_arbiter_if bus ();

  mux_sel_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    bus.d   = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    bus.d   = 4'b1111;
    repeat (3) tick();
    n_checks++;
    if (bus.gnt !== 4'b0000 || bus.sel !== 2'b00 || bus.busy !== 1'b0 || bus.y !== 1'b0 || bus.ny !== 1'b1) begin
      $display("FAIL reset_hold: gnt=%b sel=%b busy=%b y=%b ny=%b, required 0000 00 0 0 1", bus.gnt, bus.sel, bus.busy, bus.y, bus.ny);
      n_fail++;
    end
    #3 rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 || bus.y !== 1'b0) begin
      $display("FAIL reset_first_grant: gnt=%b busy=%b y=%b, required 0001 1 0", bus.gnt, bus.busy, bus.y);
      n_fail++;
    end
    tick();
    n_checks++;
    if (bus.y !== 1'b1 || bus.ny !== 1'b0) begin
      $display("FAIL reset_pre_y: y=%b ny=%b, required 1 0", bus.y, bus.ny);
      n_fail++;
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.gnt !== 4'b0000 || bus.sel !== 2'b00 || bus.busy !== 1'b0 || bus.y !== 1'b0 || bus.ny !== 1'b1) begin
      $display("FAIL reset_async: gnt=%b sel=%b busy=%b y=%b ny=%b, required 0000 00 0 0 1", bus.gnt, bus.sel, bus.busy, bus.y, bus.ny);
      n_fail++;
    end
    bus.req = 4'b0000;
    bus.d   = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    bus.d   = 4'b0101;
    bus.req = 4'b0010;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0010 || bus.sel !== 2'b01 || bus.busy !== 1'b1) begin
      $display("FAIL single_grant: gnt=%b sel=%b busy=%b, required 0010 01 1", bus.gnt, bus.sel, bus.busy);
      n_fail++;
    end
    tick();
    n_checks++;
    if (bus.y !== 1'b0 || bus.ny !== 1'b1) begin
      $display("FAIL single_y0: y=%b ny=%b, required 0 1", bus.y, bus.ny);
      n_fail++;
    end
    bus.d = 4'b0111;
    tick();
    n_checks++;
    if (bus.y !== 1'b1 || bus.ny !== 1'b0) begin
      $display("FAIL single_y1: y=%b ny=%b, required 1 0", bus.y, bus.ny);
      n_fail++;
    end
    bus.req = 4'b0000;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.y !== 1'b1) begin
      $display("FAIL single_release: busy=%b gnt=%b y=%b, required 0 0000 1", bus.busy, bus.gnt, bus.y);
      n_fail++;
    end
    tick();
    n_checks++;
    if (bus.y !== 1'b0 || bus.ny !== 1'b1) begin
      $display("FAIL single_y_idle: y=%b ny=%b, required 0 1", bus.y, bus.ny);
      n_fail++;
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_owner;
    logic [3:0] exp_gnt;
    do_reset();
    bus.req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      exp_owner = 2'((c / 4) % 4);
      exp_gnt   = 4'b0001 << exp_owner;
      n_checks++;
      if (bus.gnt !== exp_gnt || bus.sel !== exp_owner || bus.busy !== 1'b1) begin
        $display("FAIL rotation_c%0d: gnt=%b sel=%b busy=%b, required %b %b 1", c, bus.gnt, bus.sel, bus.busy, exp_gnt, exp_owner);
        n_fail++;
      end
    end
    bus.req = 4'b0000;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req = 4'b0011;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0001) begin
      $display("FAIL handoff_start: gnt=%b, required 0001", bus.gnt);
      n_fail++;
    end
    bus.req = 4'b0010;
    #4;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      $display("FAIL handoff_busy_mid: busy=%b, required 1", bus.busy);
      n_fail++;
    end
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0010 || bus.sel !== 2'b01 || bus.busy !== 1'b1) begin
      $display("FAIL handoff_edge: gnt=%b sel=%b busy=%b, required 0010 01 1", bus.gnt, bus.sel, bus.busy);
      n_fail++;
    end
    bus.req = 4'b0000;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.sel !== 2'b01) begin
      $display("FAIL handoff_idle: gnt=%b busy=%b sel=%b, required 0000 0 01", bus.gnt, bus.busy, bus.sel);
      n_fail++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (bus.gnt !== 4'b0001) begin
        $display("FAIL saturation_c%0d: gnt=%b, required 0001", c, bus.gnt);
        n_fail++;
      end
    end
    bus.req = 4'b0101;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0100 || bus.sel !== 2'b10) begin
      $display("FAIL saturation_preempt: gnt=%b sel=%b, required 0100 10", bus.gnt, bus.sel);
      n_fail++;
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    bus.req = 4'b1000;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b1000) begin
      $display("FAIL fair_owner3: gnt=%b, required 1000", bus.gnt);
      n_fail++;
    end
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b1001;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0001) begin
      $display("FAIL fair_ptr0: gnt=%b, required 0001", bus.gnt);
      n_fail++;
    end
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b1001;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b1000 || bus.sel !== 2'b11) begin
      $display("FAIL fair_ptr1: gnt=%b sel=%b, required 1000 11", bus.gnt, bus.sel);
      n_fail++;
    end
    bus.req = 4'b0000;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.d    = 4'b0000;
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_saturation();
    test_fairness();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
